// File: rtl/mom_sched.sv
// mom_sched: round-robin arbiter feeding one fixed-latency moment engine, with result tagging and drain/clear flush
module mom_sched #(
    parameter  int N_CH = 4,
    parameter  int DW   = 8,
    parameter  int RW   = 16,
    parameter  int LAT  = 2,
    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    req_valid,
    input  logic [N_CH*DW-1:0] req_data,
    output logic [N_CH-1:0]    req_ready,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               eng_valid,
    output logic [DW-1:0]      eng_data,
    output logic [CW-1:0]      eng_ch,
    output logic               eng_clr,
    input  logic [RW-1:0]      eng_result,
    output logic               res_valid,
    output logic [CW-1:0]      res_ch,
    output logic [RW-1:0]      res_data
);
    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
    localparam logic [CW:0] NC = N_CH[CW:0];
    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_rr_ptr, w_gnt, w_off;
    logic [N_CH-1:0] w_rot;
    logic [CW:0]     w_sum;
    logic            w_hit, w_xfer;
    logic            r_eng_valid;
    logic [DW-1:0]   r_eng_data;
    logic [CW-1:0]   r_eng_ch;
    logic [LAT-1:0]  r_tag_v;
    logic [CW-1:0]   r_tag_ch [LAT];
    logic            r_res_valid;
    logic [CW-1:0]   r_res_ch;
    logic [RW-1:0]   r_res_data;

    // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate the offset back
    always_comb begin
        w_rot = N_CH'({req_valid, req_valid} >> r_rr_ptr);
        w_hit = 1'b0;
        w_off = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (w_rot[i]) begin
                w_hit = 1'b1;
                w_off = CW'(i);
            end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        w_gnt = (w_sum >= NC) ? CW'(w_sum - NC) : w_sum[CW-1:0];
        req_ready = '0;
        if (rst && r_state == RUN && w_hit)
            req_ready[w_gnt] = 1'b1;
    end

    assign w_xfer = |req_ready;

    // Flush sequencing: leave DRAIN once nothing is issued or in flight, then pulse the engine clear
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     w_state_nxt = flush_req ? DRAIN : RUN;
            DRAIN:   w_state_nxt = (!r_eng_valid && !(|r_tag_v)) ? CLEAR : DRAIN;
            default: w_state_nxt = RUN;
        endcase
        flush_busy = r_state != RUN;
        eng_clr    = r_state == CLEAR;
    end

    // State, arbitration pointer and engine issue registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_rr_ptr    <= '0;
            r_eng_valid <= 1'b0;
            r_eng_data  <= '0;
            r_eng_ch    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_eng_valid <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr   <= (w_gnt == CW'(N_CH - 1)) ? '0 : w_gnt + 1'b1;
                r_eng_data <= req_data[w_gnt*DW +: DW];
                r_eng_ch   <= w_gnt;
            end
        end
    end

    // Channel tags ride alongside the engine pipe; the exiting tag captures eng_result
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag_v     <= '0;
            for (int i = 0; i < LAT; i++)
                r_tag_ch[i] <= '0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_data  <= '0;
        end else begin
            r_tag_v[0]  <= r_eng_valid;
            r_tag_ch[0] <= r_eng_ch;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_ch[i] <= r_tag_ch[i-1];
            end
            r_res_valid <= r_tag_v[LAT-1];
            if (r_tag_v[LAT-1]) begin
                r_res_ch   <= r_tag_ch[LAT-1];
                r_res_data <= eng_result;
            end
        end
    end

    assign eng_valid = r_eng_valid;
    assign eng_data  = r_eng_data;
    assign eng_ch    = r_eng_ch;
    assign res_valid = r_res_valid;
    assign res_ch    = r_res_ch;
    assign res_data  = r_res_data;
endmodule

// File: tb/tb_mom_sched.sv
// tb_mom_sched: scoreboard bench for the round-robin moment scheduler
module tb_mom_sched;
    localparam int N_CH = 4;
    localparam int DW   = 8;
    localparam int RW   = 16;
    localparam int LAT  = 2;
    localparam int CW   = 2;

    typedef struct {
        int            cyc;
        int            ch;
        logic [RW-1:0] v;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_CH-1:0]    req_valid;
    logic [N_CH*DW-1:0] req_data;
    logic [N_CH-1:0]    req_ready;
    logic               flush_req;
    logic               flush_busy;
    logic               eng_valid;
    logic [DW-1:0]      eng_data;
    logic [CW-1:0]      eng_ch;
    logic               eng_clr;
    logic [RW-1:0]      eng_result;
    logic               res_valid;
    logic [CW-1:0]      res_ch;
    logic [RW-1:0]      res_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int m_rr = 0;
    int m_st = 0;
    int g;
    bit hit;
    logic [N_CH-1:0] exp_rdy;
    logic [DW-1:0]   last_ed = '0;
    logic [CW-1:0]   last_ec = '0;
    logic [RW-1:0]   last_rd = '0;
    logic [CW-1:0]   last_rc = '0;
    ent_t q_eng[$];
    ent_t q_res[$];
    ent_t e;
    logic [RW-1:0] pipe [LAT];

    mom_sched #(.N_CH(N_CH), .DW(DW), .RW(RW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .flush_req(flush_req), .flush_busy(flush_busy),
        .eng_valid(eng_valid), .eng_data(eng_data), .eng_ch(eng_ch),
        .eng_clr(eng_clr), .eng_result(eng_result), .res_valid(res_valid),
        .res_ch(res_ch), .res_data(res_data)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] eng_fn(input logic [DW-1:0] d);
        return RW'(d) << 4;
    endfunction

    // Engine stand-in: result valid exactly LAT cycles after eng_valid, junk otherwise
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--)
            pipe[i] <= pipe[i-1];
        pipe[0] <= eng_valid ? eng_fn(eng_data) : RW'(16'hDEAD);
    end
    assign eng_result = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor/model: checks this cycle's outputs, then advances the reference model
    always @(negedge clk) begin
        hit = 1'b0;
        g = 0;
        exp_rdy = '0;
        if (rst && m_st == 0)
            for (int i = 0; i < N_CH; i++)
                if (!hit && req_valid[(m_rr + i) % N_CH]) begin
                    hit = 1'b1;
                    g = (m_rr + i) % N_CH;
                end
        if (hit)
            exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("flush_busy", 32'(flush_busy), 32'(m_st != 0));
        chk("eng_clr", 32'(eng_clr), 32'(m_st == 2));
        if (q_eng.size() > 0 && q_eng[0].cyc == cyc) begin
            e = q_eng.pop_front();
            chk("eng_valid", 32'(eng_valid), 1);
            chk("eng_ch", 32'(eng_ch), 32'(e.ch));
            chk("eng_data", 32'(eng_data), 32'(e.v[DW-1:0]));
            last_ed = e.v[DW-1:0];
            last_ec = CW'(e.ch);
        end else begin
            chk("eng_idle", 32'(eng_valid), 0);
            chk("eng_ch_hold", 32'(eng_ch), 32'(last_ec));
            chk("eng_data_hold", 32'(eng_data), 32'(last_ed));
        end
        if (q_res.size() > 0 && q_res[0].cyc == cyc) begin
            e = q_res.pop_front();
            chk("res_valid", 32'(res_valid), 1);
            chk("res_ch", 32'(res_ch), 32'(e.ch));
            chk("res_data", 32'(res_data), 32'(e.v));
            last_rd = e.v;
            last_rc = CW'(e.ch);
        end else begin
            chk("res_idle", 32'(res_valid), 0);
            chk("res_ch_hold", 32'(res_ch), 32'(last_rc));
            chk("res_data_hold", 32'(res_data), 32'(last_rd));
        end
        if (hit) begin
            q_eng.push_back('{cyc + 1, g, RW'(req_data[g*DW +: DW])});
            q_res.push_back('{cyc + LAT + 2, g, eng_fn(req_data[g*DW +: DW])});
            m_rr = (g + 1) % N_CH;
        end
        case (m_st)
            0:       m_st = flush_req ? 1 : 0;
            1:       m_st = (q_res.size() == 0) ? 2 : 1;
            default: m_st = 0;
        endcase
        if (!rst) begin
            m_st = 0;
            m_rr = 0;
            q_eng.delete();
            q_res.delete();
            last_ed = '0;
            last_ec = '0;
            last_rd = '0;
            last_rc = '0;
        end
        cyc++;
    end

    initial begin
        rst = 1'b0;
        req_valid = '1;
        req_data = '0;
        flush_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        req_valid = '0;
        repeat (3) tick();
        req_valid = 4'b0100;
        req_data = 32'h0010_0000;
        tick();
        req_valid = '0;
        repeat (LAT + 4) tick();
        req_valid = 4'b0011;
        req_data = 32'h0000_A55A;
        repeat (2) tick();
        req_valid = 4'b1000;
        req_data = 32'h7E00_0000;
        tick();
        req_valid = '0;
        repeat (LAT + 3) tick();
        req_valid = '1;
        repeat (8) begin
            req_data = $urandom;
            tick();
        end
        req_valid = '0;
        repeat (LAT + 4) tick();
        req_valid = '1;
        repeat (5) begin
            req_data = $urandom;
            tick();
        end
        flush_req = 1'b1;
        req_data = $urandom;
        repeat (2) tick();
        flush_req = 1'b0;
        repeat (12) begin
            req_data = $urandom;
            tick();
        end
        req_valid = '0;
        repeat (LAT + 4) tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (5) tick();
        req_valid = '1;
        repeat (3) begin
            req_data = $urandom;
            tick();
        end
        req_valid = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (LAT + 8) tick();
        @(negedge clk);
        chk("eng_q_empty", 32'(q_eng.size()), 0);
        chk("res_q_empty", 32'(q_res.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
